// File: rtl/bkg_tile_scan_pkg.sv
// Shared timing constants and background palette for the tile scanner.
package bkg_tile_scan_pkg;

    // 640x480 @ 60 Hz horizontal timing, in pixels
    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_TOTAL   = 800;

    // 640x480 @ 60 Hz vertical timing, in lines
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_TOTAL   = 525;

    // Tile code to 4:4:4 colour: 0 floor, 1 wall, 2..7 game colours
    localparam logic [11:0] PALETTE [0:7] = '{
        12'h000, 12'h00F, 12'h0F0, 12'hF00,
        12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF
    };

    function automatic logic [11:0] palette_lookup(input logic [2:0] code);
        return PALETTE[code];
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running 800x525 raster counters with raw (unregistered) sync and visible flags.
module vga_timing
    import bkg_tile_scan_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_ce,
    output logic [9:0] h,
    output logic [9:0] v,
    output logic       hsync,
    output logic       vsync,
    output logic       visible,
    output logic       line_end,
    output logic       frame_end
);

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    assign line_end  = (h == H_LAST);
    assign frame_end = line_end && (v == V_LAST);
    assign visible   = (h < 10'(H_VISIBLE)) && (v < 10'(V_VISIBLE));
    assign hsync     = !((h >= H_SYNC_BEG) && (h < H_SYNC_END));
    assign vsync     = !((v >= V_SYNC_BEG) && (v < V_SYNC_END));

    // Advance the raster position once per pixel enable, wrapping both axes together
    always_ff @(posedge clk) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (pix_ce) begin
            if (line_end) begin
                h <= '0;
                v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
            end else begin
                h <= h + 10'd1;
            end
        end
    end

endmodule

// File: rtl/bkg_tile_scan.sv
// Background tile scanner: walks the tile map in raster order, looks up each
// tile code through the palette and emits VGA pixels two pixel-clocks later.
module bkg_tile_scan
    import bkg_tile_scan_pkg::*;
#(
    parameter int TILE_COLS  = 20,
    parameter int TILE_ROWS  = 15,
    parameter int TILE_SHIFT = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
    output logic [8:0]  rom_addr,
    input  logic [2:0]  rom_q,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] rgb,
    output logic        frame_start
);

    localparam logic [8:0] COL_LAST      = 9'(TILE_COLS - 1);
    localparam logic [8:0] ROW_STEP      = 9'(TILE_COLS);
    localparam logic [8:0] ROW_BASE_LAST = 9'(TILE_COLS * (TILE_ROWS - 1));
    localparam logic [9:0] TILE_MASK     = 10'((1 << TILE_SHIFT) - 1);

    logic [9:0] h;
    logic [9:0] v;
    logic       hsync_p0, vsync_p0, vld_p0;
    logic       line_end, frame_end;
    logic       tile_edge_h, tile_edge_v;

    logic [8:0] col;
    logic [8:0] row_base;

    logic       vld_p1, hsync_p1, vsync_p1, fs_p1;

    vga_timing u_timing (
        .clk       (clk),
        .rst       (rst),
        .pix_ce    (pix_ce),
        .h         (h),
        .v         (v),
        .hsync     (hsync_p0),
        .vsync     (vsync_p0),
        .visible   (vld_p0),
        .line_end  (line_end),
        .frame_end (frame_end)
    );

    // Last pixel of a tile column / last line of a tile row
    assign tile_edge_h = (h & TILE_MASK) == TILE_MASK;
    assign tile_edge_v = (v & TILE_MASK) == TILE_MASK;

    // Column and row-base counters replace a row*TILE_COLS multiply; both saturate on the last tile
    always_ff @(posedge clk) begin
        if (rst) begin
            col      <= '0;
            row_base <= '0;
        end else if (pix_ce) begin
            if (line_end)
                col <= '0;
            else if (vld_p0 && tile_edge_h && col != COL_LAST)
                col <= col + 9'd1;

            if (frame_end)
                row_base <= '0;
            else if (line_end && v < 10'(V_VISIBLE) && tile_edge_v && row_base != ROW_BASE_LAST)
                row_base <= row_base + ROW_STEP;
        end
    end

    // ---- stage 0 -> stage 1: tile address out to the ROM, syncs follow ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
            vld_p1   <= 1'b0;
            hsync_p1 <= 1'b1;
            vsync_p1 <= 1'b1;
            fs_p1    <= 1'b0;
        end else if (pix_ce) begin
            rom_addr <= vld_p0 ? (row_base + col) : 9'd0;
            vld_p1   <= vld_p0;
            hsync_p1 <= hsync_p0;
            vsync_p1 <= vsync_p0;
            fs_p1    <= (h == 10'd0) && (v == 10'd0);
        end
    end

    // ---- stage 1 -> stage 2: palette colour, blanked outside the visible area ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb         <= 12'h000;
            de          <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else if (pix_ce) begin
            rgb         <= vld_p1 ? palette_lookup(rom_q) : 12'h000;
            de          <= vld_p1;
            hsync       <= hsync_p1;
            vsync       <= vsync_p1;
            frame_start <= fs_p1;
        end
    end

endmodule
